// File: rtl/keypad_onehot_capture_if.sv
// Key-side bundle of the keypad capture stage: raw key lines in, clean one-hot code and strobes out.
// The capture block is the slave; whatever drives the raw key lines uses the master modport.
interface keypad_onehot_capture_if;
  logic [9:0] key_raw;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_held;
  logic       err_multi;

  modport master (
    output key_raw,
    input  key_onehot,
    input  key_valid,
    input  key_held,
    input  err_multi
  );

  modport slave (
    input  key_raw,
    output key_onehot,
    output key_valid,
    output key_held,
    output err_multi
  );
endinterface

// File: rtl/keypad_onehot_capture.sv
// Decimal keypad front end: 2-flop sync, debounce, multi-key reject and one-hot capture.
// Define KEYPAD_AUTO_REPEAT_EN to add auto-repeat strobes while a key stays pressed.
//
// state    | meaning
// IDLE     | no key accepted; waiting for a single key line
// DEBOUNCE | single key seen; counting stable cycles before accepting it
// PRESSED  | key accepted and still held
// RELEASE  | waiting for all lines to read zero for a full debounce window
module keypad_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  keypad_onehot_capture_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  key_meta;
  logic [9:0]  key_s;
  logic [9:0]  cand;
  logic [9:0]  cand_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] cnt_inc;
  logic [3:0]  ones;
  logic        is_zero;
  logic        is_one;
  logic        is_multi;
  logic        accept;
  logic        rpt_fire;
  logic [9:0]  onehot_q;
  logic [9:0]  onehot_nxt;
  logic        valid_q;
  logic        valid_nxt;
  logic        held_q;
  logic        held_nxt;
  logic        err_q;
  logic        err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '0;
      key_s    <= '0;
    end else begin
      key_meta <= bus.key_raw;
      key_s    <= key_meta;
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, key_s[i]};
    end
  end

  assign is_zero  = (ones == 4'd0);
  assign is_one   = (ones == 4'd1);
  assign is_multi = (ones > 4'd1);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cand     <= cand_nxt;
      onehot_q <= onehot_nxt;
      valid_q  <= valid_nxt;
      held_q   <= held_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    case (state)
      IDLE: begin
        if (is_one) begin
          cand_nxt  = key_s;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key_s != cand) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (key_s != cand) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // any line coming back restarts the quiet window, so no rollover to a new key
        if (!is_zero) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    accept     = (state == DEBOUNCE) && (key_s == cand) && (cnt == DB_LAST);
    valid_nxt  = accept || rpt_fire;
    onehot_nxt = accept ? cand : onehot_q;
    held_nxt   = (state_nxt == PRESSED);
    err_nxt    = (state == IDLE) && is_multi;
  end

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_PERIOD - 1);

  logic [15:0] rpt_cnt;
  logic        rpt_armed;
  logic        pressed_stay;

  assign pressed_stay = (state == PRESSED) && (key_s == cand);
  assign rpt_fire     = pressed_stay &&
                        (rpt_armed ? (rpt_cnt == RPT_NEXT) : (rpt_cnt == RPT_FIRST));

  // rpt_armed marks that the initial delay has elapsed and the shorter period now applies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!pressed_stay) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else if (rpt_cnt != CNT_MAX) begin
      rpt_cnt <= rpt_cnt + 16'd1;
    end
  end
`else
  logic [31:0] rpt_cfg_unused;
  assign rpt_cfg_unused = REPEAT_DELAY ^ REPEAT_PERIOD;
  assign rpt_fire       = 1'b0;
`endif

  assign bus.key_onehot = onehot_q;
  assign bus.key_valid  = valid_q;
  assign bus.key_held   = held_q;
  assign bus.err_multi  = err_q;

endmodule

// File: tb/tb_keypad_onehot_capture.sv
// Bench for keypad_onehot_capture: directed scenarios plus random key traffic, every cycle
// compared against a run-length reference model of the accept/release rules.
module tb_keypad_onehot_capture;

  localparam int DC = 16;
  localparam int RD = 50;
  localparam int RP = 20;

  logic clk;
  logic rst_n;
  keypad_onehot_capture_if bus ();

  keypad_onehot_capture #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // reference model: phase 0 = free, 1 = locked on a key, 2 = waiting for all-zero window
  logic [9:0] s1_m, ks_m, cand_m, e_key;
  int         phase, run, zeros, hold;
  logic       e_valid, e_held, e_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    s1_m = '0; ks_m = '0; cand_m = '0; e_key = '0;
    phase = 0; run = 0; zeros = 0; hold = 0;
    e_valid = 1'b0; e_held = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] v);
    logic [9:0] x;
    x = ks_m;
    ks_m = s1_m;
    s1_m = v;
    e_valid = 1'b0;
    e_err   = 1'b0;
    case (phase)
      0: begin
        if (run == 0) begin
          if ($countones(x) == 1) begin
            run = 1;
            cand_m = x;
          end else if ($countones(x) > 1) begin
            e_err = 1'b1;
          end
        end else if (x != cand_m) begin
          run = 0;
        end else begin
          run++;
          if (run == DC + 1) begin
            e_valid = 1'b1;
            e_key = x;
            phase = 1;
            hold = 0;
          end
        end
      end
      1: begin
        if (x != e_key) begin
          phase = 2;
          zeros = 0;
        end else begin
          hold++;
`ifdef KEYPAD_AUTO_REPEAT_EN
          if (hold >= RD && ((hold - RD) % RP) == 0) e_valid = 1'b1;
`endif
        end
      end
      default: begin
        if (x == '0) begin
          zeros++;
          if (zeros == DC) begin
            phase = 0;
            run = 0;
          end
        end else begin
          zeros = 0;
        end
      end
    endcase
    e_held = (phase == 1);
  endtask

  task automatic step(input logic [9:0] v);
    bus.key_raw = v;
    @(posedge clk);
    model_step(v);
    #1;
    check_eq("valid",  bus.key_valid,  e_valid);
    check_eq("onehot", bus.key_onehot, e_key);
    check_eq("held",   bus.key_held,   e_held);
    check_eq("err",    bus.err_multi,  e_err);
    if (bus.key_valid) n_valid++;
    if (bus.err_multi) n_err++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_onehot"}, bus.key_onehot, 0);
    check_eq({tag, "_valid"},  bus.key_valid,  0);
    check_eq({tag, "_held"},   bus.key_held,   0);
    check_eq({tag, "_err"},    bus.err_multi,  0);
  endtask

  task automatic async_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // drives a held pattern and returns the edge index of the first key_valid (-1 if none)
  task automatic hold_key(input logic [9:0] v, input int cycles, output int first_edge);
    int base;
    first_edge = -1;
    for (int i = 0; i < cycles; i++) begin
      base = n_valid;
      step(v);
      if (n_valid != base && first_edge < 0) first_edge = i;
    end
  endtask

  initial begin
    int v0, e0, fe;
    logic [9:0] pat, saved;
    int sel, len, a, b;

    rst_n = 1'b0;
    bus.key_raw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // stable key 3 from reset release
    v0 = n_valid;
    hold_key(10'h008, 40, fe);
    check_eq("s1_first_edge", fe, 18);
    check_eq("s1_count", n_valid - v0, 1);
    check_eq("s1_onehot", bus.key_onehot, 10'h008);
    check_eq("s1_held", bus.key_held, 1);
    hold_key(10'h000, 24, fe);
    check_eq("s1_released", bus.key_held, 0);

    // bouncing key 4
    v0 = n_valid;
    for (int i = 0; i < 50; i++) step(((i / 5) % 2 == 0) ? 10'h010 : 10'h000);
    check_eq("bounce_none", n_valid - v0, 0);
    hold_key(10'h010, 30, fe);
    check_eq("bounce_one", n_valid - v0, 1);
    check_eq("bounce_onehot", bus.key_onehot, 10'h010);
    hold_key(10'h000, 24, fe);

    // two keys at once from idle
    v0 = n_valid;
    e0 = n_err;
    saved = 10'h010;
    hold_key(10'h003, 20, fe);
    check_eq("multi_err_count", n_err - e0, 18);
    check_eq("multi_no_valid", n_valid - v0, 0);
    check_eq("multi_onehot_kept", bus.key_onehot, saved);
    hold_key(10'h000, 6, fe);

    // no rollover from key 2 to key 9
    v0 = n_valid;
    hold_key(10'h004, 30, fe);
    check_eq("roll_accept2", n_valid - v0, 1);
    hold_key(10'h200, 30, fe);
    check_eq("roll_no_valid", n_valid - v0, 1);
    check_eq("roll_held_low", bus.key_held, 0);
    check_eq("roll_onehot2", bus.key_onehot, 10'h004);
    hold_key(10'h000, 20, fe);
    hold_key(10'h200, 30, fe);
    check_eq("roll_accept9", n_valid - v0, 2);
    check_eq("roll_onehot9", bus.key_onehot, 10'h200);
    hold_key(10'h000, 24, fe);

    // reset during debounce, key kept down across the reset
    hold_key(10'h001, 10, fe);
    async_reset(2);
    hold_key(10'h001, 30, fe);
    check_eq("rst_mid_edge", fe, 18);
    check_eq("rst_mid_onehot", bus.key_onehot, 10'h001);
    // reset while pressed
    async_reset(1);
    hold_key(10'h000, 24, fe);

    // long hold of key 5: repeats only when auto-repeat is built in
    v0 = n_valid;
    hold_key(10'h020, 150, fe);
`ifdef KEYPAD_AUTO_REPEAT_EN
    check_eq("hold_valid_count", n_valid - v0, 6);
`else
    check_eq("hold_valid_count", n_valid - v0, 1);
`endif
    hold_key(10'h000, 40, fe);
    check_eq("hold_after_release", n_valid - v0,
`ifdef KEYPAD_AUTO_REPEAT_EN
             6
`else
             1
`endif
    );

    // random traffic
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 29) == 0) async_reset(1);
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      a = $urandom_range(0, 9);
      b = (a + $urandom_range(1, 9)) % 10;
      pat = 10'd1 << a;
      for (int i = 0; i < len; i++) begin
        if (sel <= 1)      step(10'h000);
        else if (sel <= 6) step(pat);
        else if (sel <= 8) step(pat | (10'd1 << b));
        else               step(($urandom_range(0, 1) == 1) ? pat : 10'h000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
